// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Callers zero-extend narrower words; the padding bits do not affect the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO: head word readable without latency, full/empty/level flags,
// and a registered pulse for writes rejected while full.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_req,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full     = (r_level == LVL_FULL);
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  assign o_rd_data  = r_mem[r_rd_ptr];

  // Fullness is judged before any same-edge pop, so a full FIFO always rejects.
  assign w_wr_en = i_wr_req && !o_full;
  assign w_rd_en = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr_req && o_full;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr_en && !w_rd_en)      r_level <= r_level + LVL_ONE;
      else if (!w_wr_en && w_rd_en) r_level <= r_level - LVL_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-buffered words serialised as start/data/parity/stop frames,
// back-to-back frames sent without an idle gap.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          wr_req,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx
);

  localparam logic [15:0] TIMER_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_DATA    = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP    = 4'(STOP_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [15:0]          r_timer, w_timer_nxt;
  logic [3:0]           r_bitcnt, w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_fifo_data;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_req   (wr_req),
    .i_wr_data  (data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_level    (fifo_level),
    .o_overflow (overflow)
  );

  assign w_bit_end = (r_timer == '0);
  assign busy      = (r_state != ST_IDLE);
  assign tx        = r_tx;
  assign tx_done   = w_done;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = w_bit_end ? TIMER_RELOAD : r_timer - 16'd1;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        w_tx_nxt    = 1'b1;
        if (!fifo_empty) w_pop = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
          w_tx_nxt     = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bitcnt == LAST_DATA) begin
            w_bitcnt_nxt = '0;
            if (PARITY != PARITY_NONE) begin
              w_state_nxt = ST_PAR;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = ST_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            // Shift on the boundary so the next bit is always r_shift[0].
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            w_shift_nxt  = r_shift >> 1;
            w_tx_nxt     = r_shift[1];
          end
        end
      end
      ST_PAR: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_STOP;
          w_bitcnt_nxt = '0;
          w_tx_nxt     = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bitcnt == LAST_STOP) begin
            w_done       = 1'b1;
            w_bitcnt_nxt = '0;
            if (!fifo_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_timer_nxt = '0;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            w_tx_nxt     = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A pop always launches a new frame from the word at the FIFO head.
    if (w_pop) begin
      w_state_nxt  = ST_START;
      w_timer_nxt  = TIMER_RELOAD;
      w_bitcnt_nxt = '0;
      w_shift_nxt  = w_fifo_data;
      w_parity_nxt = parity_bit(9'(w_fifo_data), PARITY);
      w_tx_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four configurations driven from one linear sequence.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] data_bus;
  logic [3:0] wr_v;
  logic [3:0] full_v, empty_v, ovf_v, busy_v, done_v, tx_v;
  logic [4:0] lvl_a, lvl_b, lvl_d;
  logic [2:0] lvl_c;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: 8N1, B: 7E2, C: 8N1 with small FIFO and slower bit rate, D: 8O1.
  uart_tx_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .data(data_bus), .wr_req(wr_v[0]),
    .fifo_full(full_v[0]), .fifo_empty(empty_v[0]), .fifo_level(lvl_a), .overflow(ovf_v[0]),
    .busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_core #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .data(data_bus[6:0]), .wr_req(wr_v[1]),
    .fifo_full(full_v[1]), .fifo_empty(empty_v[1]), .fifo_level(lvl_b), .overflow(ovf_v[1]),
    .busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .data(data_bus), .wr_req(wr_v[2]),
    .fifo_full(full_v[2]), .fifo_empty(empty_v[2]), .fifo_level(lvl_c), .overflow(ovf_v[2]),
    .busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

  uart_tx_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d (
    .clk(clk), .rst(rst), .data(data_bus), .wr_req(wr_v[3]),
    .fifo_full(full_v[3]), .fifo_empty(empty_v[3]), .fifo_level(lvl_d), .overflow(ovf_v[3]),
    .busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits[k] is the line level of serial bit k (LSB = start bit); checks from cycle 'skip' on.
  task automatic check_frame(input int d, input logic [15:0] bits, input int nbits,
                             input int div, input int skip, input string tag);
    for (int i = skip; i < nbits * div; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_v[d]), 32'(bits[i / div]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_v[d]), 32'd1);
      chk($sformatf("%s_done%0d", tag, i), 32'(done_v[d]), 32'(i == nbits * div - 1));
      tick(1);
    end
  endtask

  initial begin
    int quiet_bad;
    rst      = 1'b0;
    data_bus = '0;
    wr_v     = '0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_tx%0d", d),    32'(tx_v[d]),    32'd1);
      chk($sformatf("rst_busy%0d", d),  32'(busy_v[d]),  32'd0);
      chk($sformatf("rst_done%0d", d),  32'(done_v[d]),  32'd0);
      chk($sformatf("rst_ovf%0d", d),   32'(ovf_v[d]),   32'd0);
      chk($sformatf("rst_empty%0d", d), 32'(empty_v[d]), 32'd1);
      chk($sformatf("rst_full%0d", d),  32'(full_v[d]),  32'd0);
    end
    chk("rst_lvl_a", 32'(lvl_a), 32'd0);
    chk("rst_lvl_b", 32'(lvl_b), 32'd0);
    chk("rst_lvl_c", 32'(lvl_c), 32'd0);
    chk("rst_lvl_d", 32'(lvl_d), 32'd0);
    tick(2);

    // A: 0x55 8N1, write presented as reset releases; pop must wait for the second edge.
    data_bus = 8'h55;
    wr_v[0]  = 1'b1;
    rst      = 1'b0;
    tick(1);
    wr_v[0] = 1'b0;
    chk("a_lvl_after_wr", 32'(lvl_a), 32'd1);
    chk("a_busy_no_early_pop", 32'(busy_v[0]), 32'd0);
    chk("a_tx_idle", 32'(tx_v[0]), 32'd1);
    tick(1);
    chk("a_lvl_after_pop", 32'(lvl_a), 32'd0);
    check_frame(0, 16'b1_01010101_0, 10, 4, 0, "a55");
    chk("a_end_busy", 32'(busy_v[0]), 32'd0);
    chk("a_end_tx", 32'(tx_v[0]), 32'd1);
    chk("a_end_done", 32'(done_v[0]), 32'd0);

    // B: 0x03 as 7 bits, even parity 0, two stop bits.
    data_bus = 8'h03;
    wr_v[1]  = 1'b1;
    tick(1);
    wr_v[1] = 1'b0;
    tick(1);
    check_frame(1, 16'b11_0_0000011_0, 11, 4, 0, "b03");
    chk("b_end_busy", 32'(busy_v[1]), 32'd0);
    chk("b_end_tx", 32'(tx_v[1]), 32'd1);

    // D: odd parity, 0x00 then 0x01 gapless.
    data_bus = 8'h00;
    wr_v[3]  = 1'b1;
    tick(1);
    data_bus = 8'h01;
    tick(1);
    wr_v[3] = 1'b0;
    check_frame(3, 16'b1_1_00000000_0, 11, 4, 0, "d00");
    check_frame(3, 16'b1_0_00000001_0, 11, 4, 0, "d01");
    chk("d_end_busy", 32'(busy_v[3]), 32'd0);
    chk("d_end_empty", 32'(empty_v[3]), 32'd1);

    // C: six back-to-back writes into a 4-deep FIFO.
    wr_v[2]  = 1'b1;
    data_bus = 8'h11; tick(1);
    data_bus = 8'h22; tick(1);
    chk("c_lvl_pop_wr", 32'(lvl_c), 32'd1);
    chk("c_busy_start", 32'(busy_v[2]), 32'd1);
    chk("c_tx_start", 32'(tx_v[2]), 32'd0);
    data_bus = 8'h33; tick(1);
    data_bus = 8'h44; tick(1);
    data_bus = 8'h99; tick(1);
    chk("c_lvl_full", 32'(lvl_c), 32'd4);
    chk("c_full", 32'(full_v[2]), 32'd1);
    chk("c_ovf_before", 32'(ovf_v[2]), 32'd0);
    data_bus = 8'hEE; tick(1);
    chk("c_ovf_pulse", 32'(ovf_v[2]), 32'd1);
    chk("c_lvl_after_drop", 32'(lvl_c), 32'd4);
    wr_v[2] = 1'b0;
    tick(1);
    chk("c_ovf_cleared", 32'(ovf_v[2]), 32'd0);
    chk("c_lvl_hold", 32'(lvl_c), 32'd4);
    check_frame(2, {6'b0, 1'b1, 8'h11, 1'b0}, 10, 16, 5, "c11");
    check_frame(2, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 16, 0, "c22");
    check_frame(2, {6'b0, 1'b1, 8'h33, 1'b0}, 10, 16, 0, "c33");
    check_frame(2, {6'b0, 1'b1, 8'h44, 1'b0}, 10, 16, 0, "c44");
    check_frame(2, {6'b0, 1'b1, 8'h99, 1'b0}, 10, 16, 0, "c99");
    chk("c_idle_busy", 32'(busy_v[2]), 32'd0);
    chk("c_idle_tx", 32'(tx_v[2]), 32'd1);
    chk("c_idle_empty", 32'(empty_v[2]), 32'd1);

    // C: write of 0xA5 while full on the same edge as a pop.
    wr_v[2]  = 1'b1;
    data_bus = 8'h5A; tick(1);
    data_bus = 8'h21; tick(1);
    data_bus = 8'hFF; tick(1);
    data_bus = 8'h42; tick(1);
    data_bus = 8'h84; tick(1);
    wr_v[2] = 1'b0;
    chk("c2_full", 32'(full_v[2]), 32'd1);
    tick(156);
    chk("c2_done_last", 32'(done_v[2]), 32'd1);
    chk("c2_full_at_pop", 32'(full_v[2]), 32'd1);
    wr_v[2]  = 1'b1;
    data_bus = 8'hA5;
    tick(1);
    wr_v[2] = 1'b0;
    chk("c2_ovf", 32'(ovf_v[2]), 32'd1);
    chk("c2_lvl_dec", 32'(lvl_c), 32'd3);
    chk("c2_not_full", 32'(full_v[2]), 32'd0);
    chk("c2_tx_start", 32'(tx_v[2]), 32'd0);
    check_frame(2, {6'b0, 1'b1, 8'h21, 1'b0}, 10, 16, 0, "c21");

    // C: reset during data bit 3 of 0xFF with two words still queued.
    chk("c3_lvl_queued", 32'(lvl_c), 32'd2);
    tick(70);
    chk("c3_tx_bit3", 32'(tx_v[2]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("c3_rst_tx", 32'(tx_v[2]), 32'd1);
    chk("c3_rst_busy", 32'(busy_v[2]), 32'd0);
    chk("c3_rst_lvl", 32'(lvl_c), 32'd0);
    chk("c3_rst_empty", 32'(empty_v[2]), 32'd1);
    chk("c3_rst_full", 32'(full_v[2]), 32'd0);
    chk("c3_rst_done", 32'(done_v[2]), 32'd0);
    chk("c3_rst_ovf", 32'(ovf_v[2]), 32'd0);
    tick(2);
    rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_v[2] !== 1'b1 || busy_v[2] !== 1'b0) quiet_bad++;
      tick(1);
    end
    chk("c3_no_frames", 32'(quiet_bad), 32'd0);
    chk("c3_lvl_final", 32'(lvl_c), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
